// File: rtl/prog_seq.sv
// Program sequencer: program counter, writable jump-target LUT and call/return stack.
// Define PROG_SEQ_STACK_EN to build the call/return stack; without it calls act as absolute jumps.
module prog_seq #(
  parameter int D         = 12,
  parameter int L         = 5,
  parameter int S         = 4,
  parameter int HALT_ADDR = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         stall,
  input  logic         reljump_en,
  input  logic         absjump_en,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic [L-1:0] lut_idx,
  input  logic         lut_wr_en,
  input  logic [L-1:0] lut_wr_idx,
  input  logic [D-1:0] lut_wr_data,
  output logic [D-1:0] prog_ctr,
  output logic         busy,
  output logic         done,
  output logic         stack_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [D-1:0] HALT = D'(HALT_ADDR);

  state_t       state, state_nxt;
  logic [D-1:0] pc, pc_nxt, pc_inc, lut_rd;
  logic [D-1:0] lut [2**L];

  assign lut_rd = lut[lut_idx];
  assign pc_inc = pc + D'(1);

  // Jump-target LUT: combinational read, so a same-edge write is seen only next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**L; i++) lut[i] <= '0;
    end else if (lut_wr_en) begin
      lut[lut_wr_idx] <= lut_wr_data;
    end
  end

`ifdef PROG_SEQ_STACK_EN
  localparam int SPW = $clog2(S + 1);
  localparam int SPI = (S > 1) ? $clog2(S) : 1;

  logic [D-1:0]   stk [S];
  logic [SPW-1:0] sp, sp_nxt, sp_dec;
  logic           err, err_nxt, push;

  assign sp_dec    = sp - SPW'(1);
  assign stack_err = err;

  always_ff @(posedge clk) begin
    if (push) stk[sp[SPI-1:0]] <= pc_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp  <= '0;
      err <= 1'b0;
    end else begin
      sp  <= sp_nxt;
      err <= err_nxt;
    end
  end
`else
  logic unused_ret;
  assign unused_ret = ret_en;
  assign stack_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
`ifdef PROG_SEQ_STACK_EN
    sp_nxt    = sp;
    err_nxt   = err;
    push      = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        if (req) begin
          state_nxt = RUN;
          pc_nxt    = '0;
`ifdef PROG_SEQ_STACK_EN
          sp_nxt    = '0;
          err_nxt   = 1'b0;
`endif
        end
      end
      RUN: begin
        // Halt wins over stall; PC freezes at HALT_ADDR
        if (pc == HALT) begin
          state_nxt = DONE;
        end else if (!stall) begin
`ifdef PROG_SEQ_STACK_EN
          if (ret_en) begin
            if (sp == '0) begin
              err_nxt = 1'b1;
              pc_nxt  = pc_inc;
            end else begin
              pc_nxt  = stk[sp_dec[SPI-1:0]];
              sp_nxt  = sp_dec;
            end
          end else if (call_en) begin
            if (sp == SPW'(S)) begin
              err_nxt = 1'b1;
              pc_nxt  = pc_inc;
            end else begin
              push    = 1'b1;
              pc_nxt  = lut_rd;
              sp_nxt  = sp + SPW'(1);
            end
          end else if (absjump_en) begin
            pc_nxt = lut_rd;
          end else if (reljump_en) begin
            pc_nxt = pc + lut_rd;
          end else begin
            pc_nxt = pc_inc;
          end
`else
          if (call_en || absjump_en) begin
            pc_nxt = lut_rd;
          end else if (reljump_en) begin
            pc_nxt = pc + lut_rd;
          end else begin
            pc_nxt = pc_inc;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign prog_ctr = pc;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_prog_seq.sv
// Directed bench for prog_seq with default parameters (D=12, L=5, S=4, HALT_ADDR=128).
module tb_prog_seq;
  logic        clk = 1'b0;
  logic        reset, req, stall, reljump_en, absjump_en, call_en, ret_en;
  logic [4:0]  lut_idx, lut_wr_idx;
  logic        lut_wr_en;
  logic [11:0] lut_wr_data, prog_ctr;
  logic        busy, done, stack_err;
  int          n_cmp = 0;
  int          n_err = 0;

  prog_seq dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall),
    .reljump_en(reljump_en), .absjump_en(absjump_en), .call_en(call_en), .ret_en(ret_en),
    .lut_idx(lut_idx), .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx), .lut_wr_data(lut_wr_data),
    .prog_ctr(prog_ctr), .busy(busy), .done(done), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 0; stall = 0; reljump_en = 0; absjump_en = 0; call_en = 0; ret_en = 0;
    lut_idx = '0; lut_wr_en = 0; lut_wr_idx = '0; lut_wr_data = '0;
  endtask

  task automatic wr_lut(input logic [4:0] idx, input logic [11:0] data);
    lut_wr_en = 1; lut_wr_idx = idx; lut_wr_data = data;
  endtask

  task automatic run_to(input logic [11:0] target);
    int n = 0;
    while (prog_ctr !== target && n < 300) begin
      cyc();
      n++;
    end
    chk("run_to", prog_ctr, target);
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    chk("rst_pc", prog_ctr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", stack_err, 0);

    // IDLE: writes land, strobes ignored
    wr_lut(5'd2, 12'h055); absjump_en = 1; lut_idx = 5'd2;
    cyc();
    wr_lut(5'd3, 12'hFFE); absjump_en = 1;
    cyc();
    idle_inputs();
    chk("idle_pc", prog_ctr, 0);
    chk("idle_busy", busy, 0);

    req = 1; cyc(); req = 0;
    chk("start_busy", busy, 1);
    chk("start_pc", prog_ctr, 0);
    cyc();
    chk("step_pc1", prog_ctr, 1);
    run_to(12'd10);

    reljump_en = 1; lut_idx = 5'd3; cyc(); reljump_en = 0;
    chk("reljump", prog_ctr, 8);
    wr_lut(5'd4, 12'h050); cyc(); lut_wr_en = 0;
    chk("step_after_rel", prog_ctr, 9);
    absjump_en = 1; lut_idx = 5'd4; cyc();
    chk("absjump", prog_ctr, 12'h050);
    // Same-index write and jump: old value used
    wr_lut(5'd4, 12'h070); cyc(); lut_wr_en = 0; absjump_en = 0;
    chk("rbw_old", prog_ctr, 12'h050);
    absjump_en = 1; cyc(); absjump_en = 0;
    chk("rbw_new", prog_ctr, 12'h070);

    // Stall with pending jump and LUT write
    stall = 1; absjump_en = 1; lut_idx = 5'd2; wr_lut(5'd5, 12'h07C);
    cyc(); chk("stall1", prog_ctr, 12'h070);
    lut_wr_en = 0;
    cyc(); chk("stall2", prog_ctr, 12'h070);
    cyc(); chk("stall3", prog_ctr, 12'h070);
    stall = 0; absjump_en = 0;
    cyc(); chk("post_stall", prog_ctr, 12'h071);
    absjump_en = 1; reljump_en = 1; lut_idx = 5'd5; cyc(); absjump_en = 0; reljump_en = 0;
    chk("prio_abs_rel", prog_ctr, 12'h07C);
    run_to(12'h080);
    chk("halt_busy", busy, 1);
    chk("halt_done", done, 0);
    stall = 1; cyc(); stall = 0;
    chk("done_flag", done, 1);
    chk("done_busy", busy, 0);
    chk("done_pc", prog_ctr, 12'h080);
    absjump_en = 1; lut_idx = 5'd2; cyc(); absjump_en = 0;
    chk("done_hold", prog_ctr, 12'h080);

    req = 1; cyc(); req = 0;
    chk("restart_pc", prog_ctr, 0);
    chk("restart_busy", busy, 1);
    run_to(12'd40);
    reset = 1; req = 1; absjump_en = 1; lut_idx = 5'd4; cyc();
    reset = 0; req = 0; absjump_en = 0;
    chk("mrst_pc", prog_ctr, 0);
    chk("mrst_busy", busy, 0);
    cyc();
    chk("mrst_idle", busy, 0);
    req = 1; cyc(); req = 0;
    absjump_en = 1; lut_idx = 5'd4; cyc(); absjump_en = 0;
    chk("lut_cleared", prog_ctr, 0);

`ifdef PROG_SEQ_STACK_EN
    wr_lut(5'd1, 12'h020); cyc(); lut_wr_en = 0;
    run_to(12'd5);
    call_en = 1; lut_idx = 5'd1;
    cyc(); chk("call1", prog_ctr, 12'h020);
    cyc(); chk("call2", prog_ctr, 12'h020);
    cyc(); chk("call3", prog_ctr, 12'h020);
    cyc(); chk("call4", prog_ctr, 12'h020);
    chk("call4_err", stack_err, 0);
    cyc(); chk("call5_ovf", prog_ctr, 12'h021);
    chk("ovf_err", stack_err, 1);
    call_en = 0; ret_en = 1;
    cyc(); chk("ret1", prog_ctr, 12'h021);
    cyc(); chk("ret2", prog_ctr, 12'h021);
    cyc(); chk("ret3", prog_ctr, 12'h021);
    cyc(); chk("ret4", prog_ctr, 12'h006);
    ret_en = 0; wr_lut(5'd6, 12'h07F); cyc(); lut_wr_en = 0;
    absjump_en = 1; lut_idx = 5'd6; cyc(); absjump_en = 0;
    chk("to_7f", prog_ctr, 12'h07F);
    cyc(); cyc();
    chk("done2", done, 1);
    chk("done2_err", stack_err, 1);
    req = 1; cyc(); req = 0;
    chk("req_clr_err", stack_err, 0);
    chk("req_clr_pc", prog_ctr, 0);
    run_to(12'd7);
    ret_en = 1; cyc(); ret_en = 0;
    chk("udf_pc", prog_ctr, 12'h008);
    chk("udf_err", stack_err, 1);
`else
    wr_lut(5'd1, 12'h020); cyc(); lut_wr_en = 0;
    chk("pre_call", prog_ctr, 1);
    call_en = 1; lut_idx = 5'd1; cyc(); call_en = 0;
    chk("call_as_abs", prog_ctr, 12'h020);
    ret_en = 1; cyc();
    chk("ret_ignored", prog_ctr, 12'h021);
    absjump_en = 1; cyc(); ret_en = 0; absjump_en = 0;
    chk("ret_abs", prog_ctr, 12'h020);
    chk("err_tied", stack_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/prog_seq.md
# prog_seq

Parametrised program sequencer: owns the program counter, a writable jump-target lookup table and an optional call/return stack. It replaces the fixed-width PC/PC_LUT pair and the hard-wired halt compare in the processor top level. It also adds a req/done start handshake and a stall input. Control decode drives the jump strobes; `prog_ctr` feeds the instruction ROM.

## Interface
Parameters:
- `D`, 12: program counter width.
- `L`, 5: LUT index width; the LUT holds 2^L entries of D bits.
- `S`, 4: call-stack depth in entries, ≥1.
- `HALT_ADDR`, 128: PC value that ends a run.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  start request; sampled only in IDLE and DONE.
- `stall`  in  1  freezes the PC and stack for this cycle.
- `reljump_en`  in  1  relative jump: PC + sign-extended LUT[lut_idx].
- `absjump_en`  in  1  absolute jump: PC = LUT[lut_idx].
- `call_en`  in  1  push PC+1, then PC = LUT[lut_idx].
- `ret_en`  in  1  PC = popped stack entry.
- `lut_idx`  in  L  LUT read index for jumps and calls.
- `lut_wr_en`  in  1  LUT write strobe.
- `lut_wr_idx`  in  L  LUT write index.
- `lut_wr_data`  in  D  LUT write data.
- `prog_ctr`  out  D  current program counter.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `stack_err`  out  1  sticky stack overflow/underflow flag.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: `req` → RUN with `prog_ctr` = 0 and stack pointer = 0.
  - RUN: when `prog_ctr` == HALT_ADDR at a clock edge, go to DONE. PC holds; `stall` does not block this transition.
  - DONE: `req` → RUN with the same clearing as from IDLE. Otherwise hold.
- `req` is ignored in RUN.
- RUN, `stall` low, PC not at HALT_ADDR: next PC by priority ret > call > absjump > reljump > PC+1.
- PC arithmetic is modulo 2^D; wrap-around is silent.
- Relative offset is LUT[lut_idx] read as a D-bit two's-complement value.
- Call with the stack full (S entries):
  - push dropped, `stack_err` set;
  - PC = PC+1.
- Ret with the stack empty:
  - `stack_err` set;
  - PC = PC+1.
- `stack_err` clears only on reset or on a `req` start.
- Jump, call and ret strobes are ignored outside RUN and while `stall` is high.
- LUT writes are accepted in every state, including during stall.

## Timing
- Reset values:
  - `prog_ctr` = 0;
  - `busy`, `done`, `stack_err` = 0;
  - state IDLE, stack pointer 0;
  - all LUT entries 0.
- A reset asserted mid-run takes effect on the same edge, overriding every other input.
- `req` high at edge N: `busy` = 1 and `prog_ctr` = 0 after edge N. The ROM sees address 0 in cycle N+1.
- Jump latency is one cycle: a strobe at edge N produces the new `prog_ctr` after edge N.
- LUT read is combinational. LUT write is on the edge.
- Same-index write and jump in one cycle: the jump uses the old LUT value (read-before-write).
- `done` rises on the edge after `prog_ctr` first equals HALT_ADDR in RUN. That is one cycle later than a combinational compare.
- Outputs are registered state or decoded directly from state. No input reaches an output combinationally.

## Configuration
- Macro: `PROG_SEQ_STACK_EN`.
- Defined: the call/return stack is implemented as above.
- Not defined:
  - no stack storage;
  - `call_en` behaves as `absjump_en` at the same priority slot, with no push;
  - `ret_en` is ignored and PC takes its normal next value;
  - `stack_err` is tied to 0.

## Test plan
- Reset, pulse `req`, no strobes, defaults → `prog_ctr` steps 0,1,…,128. `done` = 1 and `busy` = 0 on the next edge. `prog_ctr` holds at 128.
- Write LUT[3] = 0xFFE, run to PC = 10, `reljump_en` with `lut_idx` = 3 → PC = 8 next cycle. Then write LUT[4] = 0x050 and `absjump_en` → PC = 0x050.
- Stack enabled, S = 4, LUT[1] = 0x020:
  - five calls at PCs 5,0x20,0x20,0x20,0x20 → fifth call sets `stack_err` and PC = 0x021;
  - four rets → PCs 0x021,0x021,0x021,6.
- Stack empty, `ret_en` at PC 7 → PC = 8, `stack_err` = 1. A new `req` after DONE clears `stack_err` and restarts at 0.
- `stall` high for 3 cycles with `absjump_en` asserted → PC unchanged and the jump is not taken. The same-cycle LUT write still lands: a later jump reads the new value.
- `reset` asserted at PC = 40 during RUN → next cycle PC = 0, IDLE, `busy` = 0, LUT cleared. `req` is then required to restart.
